seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexing scan controller for the 4-digit seven-segment display. Holds a frame of four BCD digits plus decimal-point mask, and sequences them one digit per slot onto the shared single-digit BCD-to-segment decoder while driving the four active-low anodes. Digit updates are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits. Optional leading-zero blanking and inter-digit guard intervals against ghosting.

## Interface
- DIV_ON, 100000, clock cycles each digit is lit (≥1)
- GUARD, 16, clock cycles all anodes are off between digits (≥1)

- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- bcd_in  input  16  new frame digits; [15:12]=digit 3 (leftmost) … [3:0]=digit 0
- dp_in  input  4  new frame decimal points, bit i = digit i, 1 = lit
- load  input  1  1-cycle strobe capturing bcd_in/dp_in into the pending buffer
- lead_blank  input  1  1 = blank leading zeros of digits 3..1
- bcd_out  output  4  code to the segment decoder (b3..b0); 4'hF = blank
- an  output  4  anodes, active-low, an[i] = digit i
- dp  output  1  decimal point, active-low
- frame_tick  output  1  1-cycle pulse at each frame start (commit cycle)
- load_pending  output  1  pending buffer holds data not yet committed

## Operation
- Registers: state {GUARD, ON}, idx[1:0], cnt (wide enough for max(DIV_ON,GUARD)-1), pending bcd/dp + pending flag, active bcd/dp.
- Reset: state=GUARD, idx=0, cnt=0, pending flag=0, active bcd=16'hFFFF, active dp=4'b0000. Hence an=4'b1111, dp=1, bcd_out=4'hF, load_pending=0.
- GUARD: an=4'b1111, dp=1; bcd_out already shows digit idx. After GUARD cycles (cnt=GUARD-1) → ON, cnt=0.
- ON: an[idx]=0, others 1; dp=~active_dp[idx]. After DIV_ON cycles → GUARD, idx=idx+1 mod 4 (3→0 wraps), cnt=0.
- Commit cycle: state=GUARD, idx=0, cnt=0. frame_tick=1. If load=1 this cycle, active←bcd_in/dp_in directly (bypass), pending flag cleared. Else if pending flag=1, active←pending, flag cleared. Else active unchanged.
- load outside commit cycle: pending←bcd_in/dp_in, flag set; repeated loads before commit: last wins.
- Digit values 10–15 pass through unchanged; the decoder renders them blank.
- Leading-zero blanking (lead_blank=1): digit 3 forced to 4'hF if zero; digit 2 if zero and digits 3 zero; digit 1 if zero and digits 3,2 zero. Digit 0 never blanked. dp unaffected by blanking. Evaluated on active registers, so lead_blank takes effect immediately.
- All outputs decode from registered state and active registers only; no combinational path from bcd_in/dp_in/load to outputs.

## Timing
- Slot = GUARD+DIV_ON cycles; frame = 4×slot cycles; frame_tick period = frame.
- First post-reset cycle is a commit cycle (frame_tick=1).
- Commit latency from load: 1 cycle if load lands in a commit cycle; otherwise the next commit cycle. New data visible on bcd_out from the cycle after commit; first lit with new data at cycle GUARD after commit.
- Per-digit refresh = f_clk/frame (defaults at 100 MHz: ≈250 Hz).
- rst mid-slot: next cycle is reset state; pending load discarded.
- load and rst together: rst wins.

## Test plan
- DIV_ON=4, GUARD=2 (frame 24): reset, no load → an=1111 every cycle, bcd_out=F, frame_tick at cycles 0,24,48.
- Reset, load bcd_in=16'h1234, dp_in=4'b0100 at cycle 5 → load_pending=1 cycles 6–24; cycle 25 bcd_out=4; anodes cycles 26–29 an=1110 bcd 4, dp=1; digit 1 (bcd 3) an=1101; digit 2 (bcd 2) an=1011 with dp=0; digit 3 (bcd 1) an=0111.
- Loads 16'h1111 at cycle 30 and 16'h2222 at cycle 40 → at commit cycle 48 active=16'h2222; frame 24–47 still shows prior data.
- load 16'h5678 exactly on commit cycle 24 → load_pending never set, cycle 25 bcd_out=8.
- active=16'h0070, lead_blank=1 → digit codes 0..3 = 0,7,F,F; lead_blank=0 → 0,7,0,0; active=16'h0000, lead_blank=1 → F,F,F,0.
- rst asserted mid-ON of digit 2 after loading 16'h9999 → next cycle an=1111, bcd_out=F, frame_tick=1, load_pending=0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// Module  : seg_scan_ctrl
// Brief   : 4-digit seven-segment scan controller with frame-aligned commits,
//           leading-zero blanking and inter-digit guard intervals.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_scan_ctrl #(
    parameter int DIV_ON = 100000,
    parameter int GUARD  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        lead_blank,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_tick,
    output logic        load_pending
);

    localparam int c_CNT_MAX = (DIV_ON > GUARD) ? DIV_ON : GUARD;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_GUARD_LAST = c_CNT_W'(GUARD - 1);
    localparam logic [c_CNT_W-1:0] c_ON_LAST    = c_CNT_W'(DIV_ON - 1);

    typedef enum logic [0:0] {
        ST_GUARD = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t             r_state;
    logic [1:0]         r_idx;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_pend;
    logic [15:0]        r_pend_bcd;
    logic [3:0]         r_pend_dp;
    logic [15:0]        r_act_bcd;
    logic [3:0]         r_act_dp;

    state_t             w_state_nxt;
    logic [1:0]         w_idx_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_commit;
    logic [3:0]         w_raw;
    logic               w_z3;
    logic               w_z2;
    logic               w_z1;
    logic               w_blank;

    // The first guard cycle of digit 0 is the only point where the frame may change.
    assign w_commit = (r_state == ST_GUARD) && (r_idx == 2'd0) && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_GUARD;
            r_idx      <= 2'd0;
            r_cnt      <= '0;
            r_pend     <= 1'b0;
            r_pend_bcd <= 16'h0000;
            r_pend_dp  <= 4'b0000;
            r_act_bcd  <= 16'hFFFF;
            r_act_dp   <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_commit) begin
                r_pend <= 1'b0;
                if (load) begin
                    r_act_bcd <= bcd_in;
                    r_act_dp  <= dp_in;
                end else if (r_pend) begin
                    r_act_bcd <= r_pend_bcd;
                    r_act_dp  <= r_pend_dp;
                end
            end else if (load) begin
                r_pend     <= 1'b1;
                r_pend_bcd <= bcd_in;
                r_pend_dp  <= dp_in;
            end
        end
    end

    // Blanking looks at raw zeros of the more significant digits, not their blanked codes.
    assign w_raw = r_act_bcd[{r_idx, 2'b00} +: 4];
    assign w_z3  = (r_act_bcd[15:12] == 4'd0);
    assign w_z2  = (r_act_bcd[11:8]  == 4'd0);
    assign w_z1  = (r_act_bcd[7:4]   == 4'd0);

    always_comb begin
        w_blank = 1'b0;
        if (lead_blank) begin
            case (r_idx)
                2'd3:    w_blank = w_z3;
                2'd2:    w_blank = w_z3 && w_z2;
                2'd1:    w_blank = w_z3 && w_z2 && w_z1;
                default: w_blank = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = r_cnt + 1'b1;
        an           = 4'b1111;
        dp           = 1'b1;
        bcd_out      = w_blank ? 4'hF : w_raw;
        frame_tick   = w_commit;
        load_pending = r_pend;
        case (r_state)
            ST_GUARD: begin
                if (r_cnt == c_GUARD_LAST) begin
                    w_state_nxt = ST_ON;
                    w_cnt_nxt   = '0;
                end
            end
            ST_ON: begin
                an[r_idx] = 1'b0;
                dp        = ~r_act_dp[r_idx];
                if (r_cnt == c_ON_LAST) begin
                    w_state_nxt = ST_GUARD;
                    w_idx_nxt   = r_idx + 2'd1;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_GUARD;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
// Module  : tb_seg_scan_ctrl
// Brief   : Scoreboard bench for seg_scan_ctrl using a frame-position model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

    localparam int c_DIV_ON = 4;
    localparam int c_GUARD  = 2;
    localparam int c_SLOT   = c_DIV_ON + c_GUARD;
    localparam int c_FRAME  = 4 * c_SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic        load = 1'b0;
    logic        lead_blank = 1'b0;
    logic [3:0]  bcd_out;
    logic [3:0]  an;
    logic        dp;
    logic        frame_tick;
    logic        load_pending;

    seg_scan_ctrl #(
        .DIV_ON(c_DIV_ON),
        .GUARD (c_GUARD)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .bcd_in      (bcd_in),
        .dp_in       (dp_in),
        .load        (load),
        .lead_blank  (lead_blank),
        .bcd_out     (bcd_out),
        .an          (an),
        .dp          (dp),
        .frame_tick  (frame_tick),
        .load_pending(load_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] bcd;
        logic [3:0] an;
        logic       dp;
        logic       tick;
        logic       pend;
    } exp_t;

    exp_t q_exp[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: frame position counter plus pending/active buffers.
    int          m_pos;
    logic        m_pend;
    logic [15:0] m_pend_bcd;
    logic [3:0]  m_pend_dp;
    logic [15:0] m_act_bcd;
    logic [3:0]  m_act_dp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos      = 0;
        m_pend     = 1'b0;
        m_pend_bcd = 16'h0000;
        m_pend_dp  = 4'b0000;
        m_act_bcd  = 16'hFFFF;
        m_act_dp   = 4'b0000;
    endtask

    function automatic exp_t model_expect(input logic lb);
        exp_t e;
        int   slot;
        int   off;
        logic [3:0] d3, d2, d1;
        slot = m_pos / c_SLOT;
        off  = m_pos % c_SLOT;
        d3   = m_act_bcd[15:12];
        d2   = m_act_bcd[11:8];
        d1   = m_act_bcd[7:4];
        case (slot)
            0:       e.bcd = m_act_bcd[3:0];
            1:       e.bcd = (lb && d3 == 0 && d2 == 0 && d1 == 0) ? 4'hF : d1;
            2:       e.bcd = (lb && d3 == 0 && d2 == 0) ? 4'hF : d2;
            default: e.bcd = (lb && d3 == 0) ? 4'hF : d3;
        endcase
        if (off < c_GUARD) begin
            e.an = 4'b1111;
            e.dp = 1'b1;
        end else begin
            e.an = 4'b1111;
            e.an[slot] = 1'b0;
            e.dp = ~m_act_dp[slot];
        end
        e.tick = (m_pos == 0);
        e.pend = m_pend;
        return e;
    endfunction

    task automatic model_step(input logic ld, input logic [15:0] b, input logic [3:0] d,
                              input logic r);
        if (r) begin
            model_reset();
        end else begin
            if (m_pos == 0) begin
                if (ld) begin
                    m_act_bcd = b;
                    m_act_dp  = d;
                end else if (m_pend) begin
                    m_act_bcd = m_pend_bcd;
                    m_act_dp  = m_pend_dp;
                end
                m_pend = 1'b0;
            end else if (ld) begin
                m_pend     = 1'b1;
                m_pend_bcd = b;
                m_pend_dp  = d;
            end
            m_pos = (m_pos + 1) % c_FRAME;
        end
    endtask

    // One clock cycle: drive inputs, queue expectation, compare at negedge, advance model.
    task automatic cycle(input logic ld, input logic [15:0] b, input logic [3:0] d,
                         input logic lb, input logic r);
        exp_t e;
        load       = ld;
        bcd_in     = b;
        dp_in      = d;
        lead_blank = lb;
        rst        = r;
        q_exp.push_back(model_expect(lb));
        @(negedge clk);
        e = q_exp.pop_front();
        check("bcd_out",      {28'd0, bcd_out},      {28'd0, e.bcd});
        check("an",           {28'd0, an},           {28'd0, e.an});
        check("dp",           {31'd0, dp},           {31'd0, e.dp});
        check("frame_tick",   {31'd0, frame_tick},   {31'd0, e.tick});
        check("load_pending", {31'd0, load_pending}, {31'd0, e.pend});
        @(posedge clk);
        model_step(ld, b, d, r);
        #1;
    endtask

    task automatic idle(input int n, input logic lb);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, 4'b0000, lb, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();

        // Idle frames after reset: blank display, ticks at 0, 24, 48.
        rst = 1'b0;
        idle(50, 1'b0);

        // Load mid-frame, then two loads in the following frame (last wins).
        do_reset();
        idle(5, 1'b0);
        cycle(1'b1, 16'h1234, 4'b0100, 1'b0, 1'b0);   // cycle 5
        idle(19, 1'b0);                                // cycles 6..24
        #2;
        check("cyc25_bcd_out", {28'd0, bcd_out}, 32'h4);
        #1;
        idle(5, 1'b0);                                 // cycles 25..29
        cycle(1'b1, 16'h1111, 4'b0001, 1'b0, 1'b0);   // cycle 30
        idle(9, 1'b0);
        cycle(1'b1, 16'h2222, 4'b1000, 1'b0, 1'b0);   // cycle 40
        idle(32, 1'b0);                                // through cycle 72

        // Load landing exactly on a commit cycle bypasses the pending buffer.
        do_reset();
        idle(24, 1'b0);
        cycle(1'b1, 16'h5678, 4'b0010, 1'b0, 1'b0);   // cycle 24
        #2;
        check("bypass_bcd_out", {28'd0, bcd_out}, 32'h8);
        check("bypass_pending", {31'd0, load_pending}, 32'h0);
        #1;
        idle(10, 1'b0);

        // Leading-zero blanking, toggled on, off, and with an all-zero frame.
        do_reset();
        cycle(1'b1, 16'h0070, 4'b1111, 1'b1, 1'b0);   // cycle 0 commit
        idle(23, 1'b1);
        idle(24, 1'b0);
        cycle(1'b1, 16'h0000, 4'b0101, 1'b1, 1'b0);   // commit
        idle(23, 1'b1);
        cycle(1'b1, 16'hA0F3, 4'b0000, 1'b1, 1'b0);   // codes 10-15 pass through
        idle(24, 1'b1);

        // Reset in the middle of digit 2's lit phase, together with a load.
        do_reset();
        cycle(1'b1, 16'h9999, 4'b0000, 1'b0, 1'b0);   // cycle 0
        idle(14, 1'b0);                                // cycles 1..14
        cycle(1'b1, 16'h4321, 4'b0011, 1'b0, 1'b0);   // cycle 15, pending set
        cycle(1'b1, 16'h7777, 4'b1111, 1'b0, 1'b1);   // cycle 16, rst wins
        #2;
        check("rst_an",      {28'd0, an},           32'hF);
        check("rst_bcd_out", {28'd0, bcd_out},      32'hF);
        check("rst_tick",    {31'd0, frame_tick},   32'h1);
        check("rst_pending", {31'd0, load_pending}, 32'h0);
        #1;
        idle(30, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
